// File: rtl/uart_apb_pkg.sv
// Shared register map, bit positions and parameter defaults for the APB UART
// receive controller.
package uart_apb_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int TO_CYC_DEF = 1000;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;
  localparam logic [3:0] ADDR_THRESH = 4'hC;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_TIMEOUT   = 3;
  localparam int ST_UNDERFLOW = 4;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_W   = 7;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_IRQ_DATA = 1;
  localparam int CTRL_IRQ_TO   = 2;
  localparam int CTRL_DROP     = 3;
  localparam int CTRL_FLUSH    = 4;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// APB slave bus bundle for the UART receive controller.
interface uart_rx_ctrl_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/rx_fifo.sv
// Synchronous byte FIFO with push/pop/flush; pointers wrap naturally since
// DEPTH is a power of two.
module rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uart_rx_ctrl.sv
// APB-controlled receive path: accepts bytes from the RX stream into a FIFO,
// tracks sticky status, idle timeout and a registered level interrupt.
module uart_rx_ctrl
  import uart_apb_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic           rx_ready,
  uart_rx_ctrl_if.slave  apb,
  output logic           irq
);

  localparam int         CW     = $clog2(DEPTH + 1);
  localparam logic [15:0] TO_LIM = 16'(TO_CYC);

  logic          enable, irq_data_en, irq_to_en, drop_mode;
  logic [5:0]    thresh;
  logic          overrun, timeout, underflow;
  logic [15:0]   idle_cnt;
  logic          access, addr_err, wr_ok, rd_ok;
  logic          is_data, is_status, is_ctrl, is_thresh;
  logic          ctrl_wr, status_wr, thresh_wr, data_rd;
  logic          flush, en_now, accept, push, pop, drop, idle_clr, to_hit, irq_nxt;
  logic          full, empty;
  logic [7:0]    dout;
  logic [CW-1:0] count;
  logic          unused_ok;

  assign access    = apb.psel && apb.penable;
  assign is_data   = (apb.paddr == ADDR_DATA);
  assign is_status = (apb.paddr == ADDR_STATUS);
  assign is_ctrl   = (apb.paddr == ADDR_CTRL);
  assign is_thresh = (apb.paddr == ADDR_THRESH);
  assign addr_err  = (apb.paddr > ADDR_THRESH) || (apb.paddr[1:0] != 2'b00) ||
                     (apb.pwrite && is_data);
  assign wr_ok     = access && !addr_err && apb.pwrite;
  assign rd_ok     = access && !addr_err && !apb.pwrite;
  assign ctrl_wr   = wr_ok && is_ctrl;
  assign status_wr = wr_ok && is_status;
  assign thresh_wr = wr_ok && is_thresh;
  assign data_rd   = rd_ok && is_data;

  assign apb.pready  = 1'b1;
  assign apb.pslverr = access && addr_err;

  // A CTRL write takes effect on rx_ready in the same cycle it is issued
  assign flush    = ctrl_wr && apb.pwdata[CTRL_FLUSH];
  assign en_now   = ctrl_wr ? apb.pwdata[CTRL_EN] : enable;
  assign rx_ready = en_now && (!full || drop_mode);
  assign accept   = rx_valid && rx_ready;
  assign pop      = data_rd && !empty;
  assign push     = accept && !flush && (!full || pop);
  assign drop     = accept && !flush && full && !pop;
  assign idle_clr = accept || pop || flush || empty;
  assign to_hit   = !idle_clr && (idle_cnt == TO_LIM - 16'd1);

  assign irq_nxt = (irq_data_en && (thresh != 6'd0) &&
                    (ST_COUNT_W'(count) >= {1'b0, thresh})) ||
                   (irq_to_en && timeout) || overrun;

  assign unused_ok = ^apb.pwdata[31:6];

  rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (rx_data),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
    end else if (idle_clr) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TO_LIM) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      enable      <= 1'b0;
      irq_data_en <= 1'b0;
      irq_to_en   <= 1'b0;
      drop_mode   <= 1'b0;
      thresh      <= '0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
      underflow   <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable      <= apb.pwdata[CTRL_EN];
        irq_data_en <= apb.pwdata[CTRL_IRQ_DATA];
        irq_to_en   <= apb.pwdata[CTRL_IRQ_TO];
        drop_mode   <= apb.pwdata[CTRL_DROP];
      end
      if (thresh_wr) thresh <= apb.pwdata[5:0];
      // Sticky bits: a new event wins over a same-cycle W1C
      if (drop)                                          overrun   <= 1'b1;
      else if (status_wr && apb.pwdata[ST_OVERRUN])      overrun   <= 1'b0;
      if (to_hit)                                        timeout   <= 1'b1;
      else if (status_wr && apb.pwdata[ST_TIMEOUT])      timeout   <= 1'b0;
      if (data_rd && empty)                              underflow <= 1'b1;
      else if (status_wr && apb.pwdata[ST_UNDERFLOW])    underflow <= 1'b0;
      irq <= irq_nxt;
    end
  end

  always_comb begin
    apb.prdata = '0;
    if (rd_ok) begin
      if (is_data) begin
        apb.prdata[7:0] = empty ? 8'h00 : dout;
      end else if (is_status) begin
        apb.prdata[ST_NOT_EMPTY]               = !empty;
        apb.prdata[ST_FULL]                    = full;
        apb.prdata[ST_OVERRUN]                 = overrun;
        apb.prdata[ST_TIMEOUT]                 = timeout;
        apb.prdata[ST_UNDERFLOW]               = underflow;
        apb.prdata[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(count);
      end else if (is_ctrl) begin
        apb.prdata[CTRL_EN]       = enable;
        apb.prdata[CTRL_IRQ_DATA] = irq_data_en;
        apb.prdata[CTRL_IRQ_TO]   = irq_to_en;
        apb.prdata[CTRL_DROP]     = drop_mode;
      end else if (is_thresh) begin
        apb.prdata[5:0] = thresh;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: register table plus FIFO/irq/timeout
// sequences checked against a byte-queue scoreboard.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       irq;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.DEPTH(DEPTH), .TO_CYC(20)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .apb      (bus),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] q [$];

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                      input logic bv, input logic [7:0] b,
                      output logic [31:0] rd, output logic err, output logic rdy);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wd;
    @(negedge clk);
    bus.penable = 1'b1; rx_valid = bv; rx_data = b;
    #1;
    rd = bus.prdata; err = bus.pslverr; rdy = rx_ready;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic wr_reg(input string name, input logic [3:0] addr, input logic [31:0] wd);
    logic [31:0] rd; logic err, rdy;
    xfer(1'b1, addr, wd, 1'b0, 8'h00, rd, err, rdy);
    check({name, "_err"}, err, 0);
  endtask

  task automatic rd_reg(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic err, rdy;
    xfer(1'b0, addr, 32'h0, 1'b0, 8'h00, rd, err, rdy);
    check(name, rd, exp);
    check({name, "_err"}, err, 0);
  endtask

  task automatic rd_data(input string name);
    logic [31:0] rd; logic err, rdy; logic [7:0] exp;
    exp = (q.size() > 0) ? q.pop_front() : 8'h00;
    xfer(1'b0, 4'h0, 32'h0, 1'b0, 8'h00, rd, err, rdy);
    check(name, rd, {24'h0, exp});
  endtask

  task automatic send(input string name, input logic [7:0] b, input logic exp_rdy);
    logic rdy;
    rx_valid = 1'b1; rx_data = b;
    #1;
    rdy = rx_ready;
    @(negedge clk);
    rx_valid = 1'b0;
    check({name, "_rdy"}, rdy, exp_rdy);
    if (rdy && q.size() < DEPTH) q.push_back(b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd; logic err, rdy; int cyc; logic [7:0] hd;

    vt[0]  = '{1'b0, 4'h4, 32'h0,        32'h0,  1'b0};
    vt[1]  = '{1'b0, 4'h8, 32'h0,        32'h0,  1'b0};
    vt[2]  = '{1'b0, 4'hC, 32'h0,        32'h0,  1'b0};
    vt[3]  = '{1'b1, 4'hC, 32'h3F,       32'h0,  1'b0};
    vt[4]  = '{1'b0, 4'hC, 32'h0,        32'h3F, 1'b0};
    vt[5]  = '{1'b1, 4'hC, 32'hFFFFFFC5, 32'h0,  1'b0};
    vt[6]  = '{1'b0, 4'hC, 32'h0,        32'h05, 1'b0};
    vt[7]  = '{1'b1, 4'hC, 32'h0,        32'h0,  1'b0};
    vt[8]  = '{1'b0, 4'hD, 32'h0,        32'h0,  1'b1};
    vt[9]  = '{1'b0, 4'h2, 32'h0,        32'h0,  1'b1};
    vt[10] = '{1'b1, 4'h0, 32'h55,       32'h0,  1'b1};
    vt[11] = '{1'b1, 4'h8, 32'h1E,       32'h0,  1'b0};
    vt[12] = '{1'b0, 4'h8, 32'h0,        32'h0E, 1'b0};
    vt[13] = '{1'b1, 4'h8, 32'h0,        32'h0,  1'b0};
    vt[14] = '{1'b0, 4'h4, 32'h0,        32'h0,  1'b0};
    vt[15] = '{1'b1, 4'h6, 32'hFFFF,     32'h0,  1'b1};
    vt[16] = '{1'b0, 4'h4, 32'h0,        32'h0,  1'b0};

    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 4'h0; bus.pwdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_rx_ready", rx_ready, 0);
    check("reset_irq", irq, 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      xfer(vt[i].wr, vt[i].addr, vt[i].wd, 1'b0, 8'h00, rd, err, rdy);
      check($sformatf("vec%0d_err", i), err, vt[i].exp_err);
      if (!vt[i].wr && !vt[i].exp_err) check($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
    end

    // Basic ordering
    wr_reg("ctrl_en", 4'h8, 32'h1);
    send("b11", 8'h11, 1'b1);
    send("b22", 8'h22, 1'b1);
    send("b33", 8'h33, 1'b1);
    rd_data("pop1"); rd_data("pop2"); rd_data("pop3");
    rd_reg("status_empty", 4'h4, 32'h0);

    // Fill, reject, drop with overrun, pop+push while full
    for (int i = 0; i < DEPTH; i++) send($sformatf("fill%0d", i), 8'h40 + 8'(i), 1'b1);
    check("full_rx_ready", rx_ready, 0);
    send("full_nodrop", 8'h99, 1'b0);
    rd_reg("status_full", 4'h4, 32'h803);
    wr_reg("ctrl_drop", 4'h8, 32'h9);
    send("drop_aa", 8'hAA, 1'b1);
    @(negedge clk);
    check("irq_overrun", irq, 1);
    rd_reg("status_ovr", 4'h4, 32'h807);
    rd_data("head_after_drop");
    wr_reg("clr_ovr", 4'h4, 32'h4);
    send("refill", 8'h77, 1'b1);
    rd_reg("status_refull", 4'h4, 32'h803);
    hd = q.pop_front();
    xfer(1'b0, 4'h0, 32'h0, 1'b1, 8'hC3, rd, err, rdy);
    check("popush_rd", rd, {24'h0, hd});
    check("popush_rdy", rdy, 1);
    q.push_back(8'hC3);
    rd_reg("status_popush", 4'h4, 32'h803);
    for (int i = 0; i < DEPTH; i++) rd_data($sformatf("drain%0d", i));
    rd_reg("status_drained", 4'h4, 32'h0);
    check("irq_cleared", irq, 0);
    wr_reg("ctrl_en2", 4'h8, 32'h1);

    // Underflow
    rd_data("underflow_rd");
    rd_reg("status_unf", 4'h4, 32'h10);
    wr_reg("clr_unf", 4'h4, 32'h10);
    rd_reg("status_unf_clr", 4'h4, 32'h0);

    // Threshold interrupt
    wr_reg("thresh4", 4'hC, 32'h4);
    wr_reg("ctrl_irqd", 4'h8, 32'h3);
    for (int i = 0; i < 4; i++) send($sformatf("th%0d", i), 8'hB0 + 8'(i), 1'b1);
    check("irq_th_latency", irq, 0);
    @(negedge clk);
    check("irq_th_set", irq, 1);
    rd_data("th_pop");
    @(negedge clk);
    check("irq_th_clr", irq, 0);
    for (int i = 0; i < 3; i++) rd_data($sformatf("th_drain%0d", i));
    wr_reg("thresh0", 4'hC, 32'h0);

    // Idle timeout, flush, flush with concurrent byte
    wr_reg("ctrl_irqto", 4'h8, 32'h5);
    send("to_byte", 8'hD1, 1'b1);
    cyc = 0;
    while (cyc < 40 && irq !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    check("to_irq_cycles", cyc, 21);
    rd_reg("status_to", 4'h4, 32'h109);
    wr_reg("flush", 4'h8, 32'h15);
    q.delete();
    rd_reg("status_flushed", 4'h4, 32'h8);
    xfer(1'b1, 4'h8, 32'h15, 1'b1, 8'h55, rd, err, rdy);
    check("flush_byte_rdy", rdy, 1);
    rd_reg("status_flush_byte", 4'h4, 32'h8);
    wr_reg("clr_to", 4'h4, 32'h8);
    rd_reg("status_to_clr", 4'h4, 32'h0);
    @(negedge clk);
    check("irq_to_clr", irq, 0);
    wr_reg("ctrl_en3", 4'h8, 32'h1);

    // Error access without side effects, then reset with stored bytes
    send("r1", 8'hE1, 1'b1);
    send("r2", 8'hE2, 1'b1);
    send("r3", 8'hE3, 1'b1);
    xfer(1'b1, 4'h0, 32'hFF, 1'b0, 8'h00, rd, err, rdy);
    check("wr_data_err", err, 1);
    rd_reg("status_3", 4'h4, 32'h301);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_irq", irq, 0);
    rstn = 1'b1;
    q.delete();
    @(negedge clk);
    rd_reg("status_after_rst", 4'h4, 32'h0);
    rd_reg("ctrl_after_rst", 4'h8, 32'h0);
    wr_reg("ctrl_en4", 4'h8, 32'h1);
    send("new_head", 8'h5A, 1'b1);
    rd_data("new_head_rd");
    rd_reg("status_final", 4'h4, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
